// File: rtl/inst_mem_if.sv
// inst_mem_if: loader/fetch bus of inst_mem_loadable; master = loader+fetch unit, slave = memory
interface inst_mem_if #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8
);
  logic                       load_en;
  logic                       ld_valid;
  logic [WIDTH-1:0]           ld_data;
  logic                       ld_ready;
  logic [$clog2(DEPTH):0]     ld_count;
  logic                       ld_full;
  logic                       fetch_req;
  logic [4*WIDTH-1:0]         read_address;
  logic [4*WIDTH-1:0]         rd;
  logic                       rd_valid;
  logic                       fetch_err;
  modport master (
    output load_en, ld_valid, ld_data, fetch_req, read_address,
    input  ld_ready, ld_count, ld_full, rd, rd_valid, fetch_err
  );
  modport slave (
    input  load_en, ld_valid, ld_data, fetch_req, read_address,
    output ld_ready, ld_count, ld_full, rd, rd_valid, fetch_err
  );
endinterface

// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable: byte memory with serial program-load port and registered 4-byte little-endian fetch; ports clk, rst, bus (load_en/ld_* loader side, fetch_req/read_address -> rd/rd_valid/fetch_err)
module inst_mem_loadable #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  inst_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4*WIDTH-1:0] LAST = (4*WIDTH)'(DEPTH - 4);
  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ra;
  logic wr, fire, bad;
  logic [4*WIDTH-1:0] word;
  always_comb begin
    state_n = (state == RUN) ? (bus.load_en ? LOAD : RUN) :
              (state == LOAD) ? (bus.load_en ? LOAD : DONE) : RUN;
    bus.ld_ready = (state == LOAD) && !bus.ld_full;
    wr = bus.ld_ready && bus.ld_valid;
    fire = (state == RUN) && bus.fetch_req;
    ra = bus.read_address[AW-1:0];
    bad = (bus.read_address[1:0] != 2'b00) || (bus.read_address > LAST);
    word = {mem[ra + AW'(3)], mem[ra + AW'(2)], mem[ra + AW'(1)], mem[ra]};
  end
  // the write pointer is the byte count itself; it never reaches DEPTH while writing
  always_ff @(posedge clk)
    if (wr) mem[bus.ld_count[AW-1:0]] <= bus.ld_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      bus.ld_count  <= '0;
      bus.ld_full   <= 1'b0;
      bus.rd        <= '0;
      bus.rd_valid  <= 1'b0;
      bus.fetch_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == RUN && bus.load_en) begin
        bus.ld_count <= '0;
        bus.ld_full  <= 1'b0;
      end else if (wr) begin
        bus.ld_count <= bus.ld_count + CW'(1);
        bus.ld_full  <= bus.ld_count == CW'(DEPTH - 1);
      end
      bus.rd_valid  <= fire;
      bus.fetch_err <= fire && bad;
      if (fire) bus.rd <= bad ? '0 : word;
    end
  end
endmodule

// File: tb/tb_inst_mem_loadable.sv
// tb_inst_mem_loadable: directed scoreboard bench for inst_mem_loadable
module tb_inst_mem_loadable;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] model [DEPTH];
  logic [32:0] sb [$];
  int checks = 0;
  int errors = 0;
  inst_mem_if #(.DEPTH(DEPTH), .WIDTH(8)) bus ();
  inst_mem_loadable #(.DEPTH(DEPTH), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] expw(input logic [31:0] a);
    int i;
    if (a[1:0] != 2'b00 || a > 32'(DEPTH - 4)) return {1'b1, 32'h0};
    i = int'(a);
    return {1'b0, model[i+3], model[i+2], model[i+1], model[i]};
  endfunction
  task automatic fetch(input logic [31:0] a, input logic [32:0] e);
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.read_address = a;
    sb.push_back(e);
    @(negedge clk);
    bus.fetch_req = 1'b0;
  endtask
  task automatic load(input int n, input int mode);
    @(negedge clk);
    bus.load_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data = (mode == 0) ? 8'(8'h11 * (i + 1)) : (mode == 1) ? (8'(i) ^ 8'hA5) : 8'(8'hC1 + i);
      if (i < DEPTH) model[i] = bus.ld_data;
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
  endtask
  task automatic end_load();
    bus.load_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (bus.rd_valid) begin
      if (sb.size() == 0) chk("unexpected_rd_valid", 64'(bus.rd_valid), 64'd0);
      else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("rd", 64'(bus.rd), 64'(e[31:0]));
        chk("fetch_err", 64'(bus.fetch_err), 64'(e[32]));
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = 8'(i * 7 + 3);
      dut.mem[i] = model[i];
    end
    rst = 1'b1;
    bus.load_en = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.fetch_req = 1'b0;
    bus.read_address = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
    chk("rst_ld_count", 64'(bus.ld_count), 64'd0);
    chk("rst_ld_full", 64'(bus.ld_full), 64'd0);
    chk("rst_rd", 64'(bus.rd), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_fetch_err", 64'(bus.fetch_err), 64'd0);
    fetch(32'd0, expw(32'd0));
    @(negedge clk);
    chk("rd_hold", 64'(bus.rd), 64'(expw(32'd0) & 33'h0_FFFF_FFFF));
    chk("rd_valid_one_cycle", 64'(bus.rd_valid), 64'd0);
    load(8, 0);
    chk("load_ready", 64'(bus.ld_ready), 64'd1);
    end_load();
    chk("load8_count", 64'(bus.ld_count), 64'd8);
    fetch(32'd4, {1'b0, 32'h88776655});
    fetch(32'd0, {1'b0, 32'h44332211});
    fetch(32'd2, {1'b1, 32'h0});
    fetch(32'(DEPTH - 4), expw(32'(DEPTH - 4)));
    fetch(32'(DEPTH), {1'b1, 32'h0});
    fetch(32'hFFFF_FFFC, {1'b1, 32'h0});
    load(DEPTH + 3, 1);
    chk("full_flag", 64'(bus.ld_full), 64'd1);
    chk("full_ready", 64'(bus.ld_ready), 64'd0);
    chk("full_count", 64'(bus.ld_count), 64'(DEPTH));
    end_load();
    chk("count_held", 64'(bus.ld_count), 64'(DEPTH));
    fetch(32'd0, {1'b0, 32'hA6A7A4A5});
    fetch(32'(DEPTH - 4), expw(32'(DEPTH - 4)));
    @(negedge clk);
    bus.fetch_req = 1'b1;
    for (int a = 0; a < 12; a += 4) begin
      bus.read_address = 32'(a);
      sb.push_back(expw(32'(a)));
      @(negedge clk);
      chk("b2b_valid", 64'(bus.rd_valid), 64'd1);
    end
    bus.read_address = 32'd16;
    bus.load_en = 1'b1;
    sb.push_back(expw(32'd16));
    @(negedge clk);
    chk("rise_fetch_valid", 64'(bus.rd_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("load_fetch_ignored", 64'(bus.rd_valid), 64'd0);
    end
    bus.fetch_req = 1'b0;
    end_load();
    chk("empty_load_count", 64'(bus.ld_count), 64'd0);
    load(5, 2);
    chk("pre_rst_count", 64'(bus.ld_count), 64'd5);
    rst = 1'b1;
    bus.load_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_count", 64'(bus.ld_count), 64'd0);
    chk("mid_rst_ready", 64'(bus.ld_ready), 64'd0);
    fetch(32'd0, {1'b0, 32'hC4C3C2C1});
    fetch(32'd4, {1'b0, model[7], model[6], model[5], 8'hC5});
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
